// File: rtl/fsm_mon_pkg.sv
// Shared types and helpers for the FSM state-code monitor.
package fsm_mon_pkg;

  typedef enum logic [1:0] {
    INIT,
    TRACK,
    FAULT
  } mon_state_t;

  localparam int unsigned IDLE_CODE = 0;
  localparam int unsigned NUM_LEGAL = 4;

  // Allowed moves on the 4-state ring: hold, step forward, or abort to idle.
  function automatic logic is_legal_trans(input logic [1:0] prev_code,
                                          input logic [1:0] next_code);
    return (next_code == prev_code) ||
           (next_code == 2'(prev_code + 2'd1)) ||
           (next_code == 2'(IDLE_CODE));
  endfunction

endpackage

// File: rtl/fsm_code_monitor_if.sv
// Code stream from a protected FSM to its monitor.
interface fsm_code_monitor_if #(
  parameter int unsigned CODE_W = 3
);
  logic [CODE_W-1:0] fsm_code;
  logic              code_valid;

  modport master (output fsm_code, output code_valid);
  modport slave  (input  fsm_code, input  code_valid);
endinterface

// File: rtl/fsm_mon_sat_cnt.sv
// Saturating up-counter; a clear in the same cycle as an increment yields 1.
module fsm_mon_sat_cnt #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= inc ? CNT_W'(1) : '0;
    end else if (inc && (q != '1)) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/fsm_code_monitor.sv
// Receive-side checker for a 4-state FSM code stream: decode, dwell, fault latch.
// Optional dwell timeout enabled by defining FSM_MON_TIMEOUT_EN.
module fsm_code_monitor
  import fsm_mon_pkg::*;
#(
  parameter int unsigned CODE_W    = 3,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned DWELL_MAX = 200
) (
  input  logic                clk,
  input  logic                rst_n,
  fsm_code_monitor_if.slave   code_if,
  input  logic                err_clr,
  output logic [1:0]          cur_state,
  output logic [CNT_W-1:0]    dwell_cnt,
  output logic                illegal_code,
  output logic                illegal_trans,
  output logic                timeout,
  output logic                err_sticky,
  output logic [CNT_W-1:0]    err_count,
  output logic                safe_req
);

  if (DWELL_MAX == 0 || DWELL_MAX >= (1 << CNT_W)) begin : g_dwell_range
    $error("DWELL_MAX must fit below dwell counter saturation");
  end

  mon_state_t state, eff_state, next_state;
  logic [1:0] prev_code, next_prev, next_cur, code2;
  logic       code_legal, ic_hit, it_hit, fault, dwell_inc, dwell_clr;
`ifdef FSM_MON_TIMEOUT_EN
  logic       to_hit;
`endif

  assign code2      = code_if.fsm_code[1:0];
  assign code_legal = (code_if.fsm_code < CODE_W'(NUM_LEGAL));

  // err_clr out of FAULT is applied before the current sample is judged,
  // so a fault in the same cycle lands on a freshly cleared monitor.
  always_comb begin
    eff_state  = (err_clr && state == FAULT) ? INIT : state;
    next_state = eff_state;
    next_cur   = cur_state;
    next_prev  = prev_code;
    ic_hit     = 1'b0;
    it_hit     = 1'b0;
    dwell_inc  = 1'b0;
    dwell_clr  = err_clr && (state == FAULT);
`ifdef FSM_MON_TIMEOUT_EN
    to_hit     = 1'b0;
`endif
    if (code_if.code_valid) begin
      if (!code_legal) begin
        ic_hit     = 1'b1;
        next_state = FAULT;
      end else begin
        case (eff_state)
          INIT: begin
            next_cur   = code2;
            next_prev  = code2;
            dwell_clr  = 1'b1;
            next_state = TRACK;
          end
          TRACK: begin
            next_prev = code2;
            if (!is_legal_trans(prev_code, code2)) begin
              it_hit     = 1'b1;
              next_state = FAULT;
            end else begin
              next_cur = code2;
              if (code2 == prev_code) begin
                dwell_inc = 1'b1;
`ifdef FSM_MON_TIMEOUT_EN
                if (cur_state != 2'(IDLE_CODE) &&
                    dwell_cnt == CNT_W'(DWELL_MAX - 1)) begin
                  to_hit     = 1'b1;
                  next_state = FAULT;
                end
`endif
              end else begin
                dwell_clr = 1'b1;
              end
            end
          end
          FAULT: begin
            next_prev = code2;
            it_hit    = !is_legal_trans(prev_code, code2);
          end
          default: ;
        endcase
      end
    end
  end

`ifdef FSM_MON_TIMEOUT_EN
  assign fault = ic_hit | it_hit | to_hit;
`else
  assign fault = ic_hit | it_hit;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= INIT;
      prev_code     <= '0;
      cur_state     <= '0;
      illegal_code  <= 1'b0;
      illegal_trans <= 1'b0;
      err_sticky    <= 1'b0;
      safe_req      <= 1'b0;
    end else begin
      state         <= next_state;
      prev_code     <= next_prev;
      cur_state     <= next_cur;
      illegal_code  <= ic_hit;
      illegal_trans <= it_hit;
      safe_req      <= (next_state == FAULT);
      if (fault) begin
        err_sticky <= 1'b1;
      end else if (err_clr) begin
        err_sticky <= 1'b0;
      end
    end
  end

`ifdef FSM_MON_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout <= 1'b0;
    end else begin
      timeout <= to_hit;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  fsm_mon_sat_cnt #(.CNT_W(CNT_W)) u_dwell_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (dwell_clr),
    .inc   (dwell_inc),
    .q     (dwell_cnt)
  );

  fsm_mon_sat_cnt #(.CNT_W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (err_clr),
    .inc   (fault),
    .q     (err_count)
  );

endmodule
